roic_readout_sequencer: RTL
===========================

ROIC_READOUT_SEQUENCER -- requirements
Module: roic_readout_sequencer

Interface
REQ-001 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  single clock, all logic rising-edge
- rst  in  1  synchronous, active-high reset
- frame_start  in  1  one-cycle request to read one frame
- abort  in  1  terminate current frame
- integ_cycles  in  16  integration time in clk cycles
- hold_cycles  in  8  extra column-hold cycles
- gap_cycles  in  8  inter-column delay in cycles
- row_first/row_last  in  9  row window, inclusive
- col_first/col_last  in  10  column window, inclusive
- sample_ack  in  1  ADC accepted the sample
- row_addr  out  9  selected row index
- col_addr  out  10  selected column index
- row_en  out  1  row select
- col_en  out  1  column select
- sample_req  out  1  ADC convert request
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle completion pulse
- cfg_err  out  1  one-cycle bad-window pulse

Function
REQ-002 The FSM SHALL have states IDLE, INTEGRATE, ROW_SETUP, COL_HOLD, SAMPLE, COL_GAP and DONE; all outputs SHALL be registered.
REQ-003 In IDLE, frame_start SHALL latch all config inputs; frame_start in any other state SHALL be ignored.
REQ-004 If the latched window is invalid (row_first>row_last, row_last>511, col_first>col_last, col_last>639), the block SHALL pulse cfg_err for 1 cycle and remain in IDLE.
REQ-005 A valid window SHALL enter INTEGRATE with busy=1; INTEGRATE SHALL last max(integ_cycles,1) cycles.
REQ-006 ROW_SETUP SHALL last 1 cycle with row_en=1, row_addr=current row, col_addr=col_first on the first row, col_en=0.
REQ-007 COL_HOLD SHALL last hold_cycles+1 cycles with col_en=1.
REQ-008 SAMPLE SHALL hold sample_req=1 and col_en=1 until the cycle sample_ack=1; sample_req SHALL drop the following cycle.
REQ-009 On ack: if col_addr<col_last, col_addr SHALL increment and the FSM SHALL go to COL_GAP, or directly to COL_HOLD if gap_cycles=0.
REQ-010 On ack: if col_addr=col_last and row_addr<row_last, row_addr SHALL increment, col_addr SHALL reload col_first, and the FSM SHALL go to ROW_SETUP.
REQ-011 On ack at col_last/row_last, the FSM SHALL go to DONE.
REQ-012 COL_GAP SHALL last gap_cycles cycles with col_en=0 and row_en=1.
REQ-013 DONE SHALL last 1 cycle, pulse frame_done and clear busy, row_en and col_en, then return to IDLE.
REQ-014 In any non-IDLE state, abort SHALL return the FSM to IDLE on the next cycle with all outputs cleared and no frame_done; abort SHALL take priority over a simultaneous sample_ack.
REQ-015 Counters SHALL never wrap: row_addr≤511 and col_addr≤639 always.

Reset
REQ-016 While rst=1, state SHALL be IDLE and every output SHALL be 0; rst mid-frame SHALL behave as abort, and the next frame SHALL require a new frame_start.

Configuration
REQ-017 With ROIC_SEQ_TESTPAT_EN defined, the block SHALL add input tp_mode (1 bit); when tp_mode=1, SAMPLE SHALL self-acknowledge after exactly 1 cycle and ignore sample_ack.
REQ-018 Without ROIC_SEQ_TESTPAT_EN, the tp_mode port and logic SHALL be absent, and only sample_ack SHALL advance SAMPLE.

Structure
REQ-019 The package roic_seq_pkg SHALL hold the state typedef, ROIC_ROWS=512, ROIC_COLS=640 and the address widths.
REQ-020 A sub-module roic_delay_timer (loadable 16-bit down-counter with an expiry flag) SHALL time the INTEGRATE, COL_HOLD and COL_GAP states.

Verification
REQ-021 The bench SHALL cover these scenarios:
- Rows 0–1, cols 0–1, integ=5, hold=3, gap=2, ack same cycle as req -> 4 sample_req pulses at (0,0),(0,1),(1,0),(1,1); frame_done exactly once; busy drops with frame_done.
- row_first=10, row_last=5 -> cfg_err 1 cycle, busy stays 0, no row_en.
- Window rows 511, cols 638–639 -> last sample at (511,639); no address exceeds its limit.
- sample_ack delayed 7 cycles -> sample_req held 7 cycles, then col advances.
- abort during the third COL_HOLD -> next cycle all outputs 0, no frame_done; a new frame_start then runs normally.
- gap_cycles=0, integ_cycles=0 -> INTEGRATE lasts 1 cycle; SAMPLE goes directly to COL_HOLD.

Source files
------------

// File: rtl/roic_seq_pkg.sv
// roic_seq_pkg
// Shared definitions for the ROIC readout sequencer: array geometry, address
// widths, the sequencer state encoding and a readout-window validity helper.
package roic_seq_pkg;

  localparam int ROIC_ROWS = 512;
  localparam int ROIC_COLS = 640;
  localparam int ROW_AW    = 9;
  localparam int COL_AW    = 10;
  localparam int TMR_W     = 16;

  localparam logic [15:0] ROW_MAX = 16'(ROIC_ROWS - 1);
  localparam logic [15:0] COL_MAX = 16'(ROIC_COLS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INTEGRATE,
    ST_ROW_SETUP,
    ST_COL_HOLD,
    ST_SAMPLE,
    ST_COL_GAP,
    ST_DONE
  } seq_state_t;

  // Arguments are widened to 16 bits so the limit compares are meaningful
  // even though the ports themselves cannot exceed them for rows.
  function automatic logic window_ok(input logic [15:0] rf, input logic [15:0] rl,
                                     input logic [15:0] cf, input logic [15:0] cl);
    return (rf <= rl) && (rl <= ROW_MAX) && (cf <= cl) && (cl <= COL_MAX);
  endfunction

endpackage

// File: rtl/roic_delay_timer.sv
// roic_delay_timer
// Loadable down-counter used to time sequencer states. A load of N makes
// o_expired-equivalent output high after N further cycles, so a state that
// exits on expiry lasts N+1 cycles.
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   load      load load_val this cycle
//   load_val  value to load
//   expired   count has reached zero
module roic_delay_timer
  import roic_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [TMR_W-1:0] load_val,
  output logic             expired
);

  logic [TMR_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign expired = (r_cnt == '0);

endmodule

// File: rtl/roic_readout_sequencer.sv
// roic_readout_sequencer
// Walks a rectangular row/column window of a readout IC once per frame_start:
// integrate, then per row a setup cycle, and per column a hold period, an ADC
// sample handshake and an optional inter-column gap. All outputs registered.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   frame_start, abort       frame request / terminate frame
//   integ_cycles, hold_cycles, gap_cycles   timing configuration
//   row_first/row_last, col_first/col_last  inclusive readout window
//   sample_ack               ADC accepted the sample
//   row_addr, col_addr       current pixel address
//   row_en, col_en           row / column select
//   sample_req               ADC convert request
//   busy, frame_done, cfg_err status
//   tp_mode                  (only with ROIC_SEQ_TESTPAT_EN) self-ack SAMPLE
// Build option: define ROIC_SEQ_TESTPAT_EN to add the test-pattern input.
//
// state        | meaning
// IDLE         | waiting for frame_start, config latched on request
// INTEGRATE    | integration period, max(integ_cycles,1) cycles
// ROW_SETUP    | one cycle with new row selected, column deselected
// COL_HOLD     | column held selected for hold_cycles+1 cycles
// SAMPLE       | sample_req asserted until acknowledged
// COL_GAP      | inter-column delay of gap_cycles cycles
// DONE         | one-cycle frame_done pulse
module roic_readout_sequencer
  import roic_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic              abort,
  input  logic [15:0]       integ_cycles,
  input  logic [7:0]        hold_cycles,
  input  logic [7:0]        gap_cycles,
  input  logic [ROW_AW-1:0] row_first,
  input  logic [ROW_AW-1:0] row_last,
  input  logic [COL_AW-1:0] col_first,
  input  logic [COL_AW-1:0] col_last,
  input  logic              sample_ack,
`ifdef ROIC_SEQ_TESTPAT_EN
  input  logic              tp_mode,
`endif
  output logic [ROW_AW-1:0] row_addr,
  output logic [COL_AW-1:0] col_addr,
  output logic              row_en,
  output logic              col_en,
  output logic              sample_req,
  output logic              busy,
  output logic              frame_done,
  output logic              cfg_err
);

  seq_state_t        r_state;
  seq_state_t        w_state_nxt;

  logic [7:0]        r_hold;
  logic [7:0]        r_gap;
  logic [ROW_AW-1:0] r_row_last;
  logic [COL_AW-1:0] r_col_first;
  logic [COL_AW-1:0] r_col_last;

  logic [ROW_AW-1:0] r_row_addr;
  logic [COL_AW-1:0] r_col_addr;
  logic [ROW_AW-1:0] w_row_nxt;
  logic [COL_AW-1:0] w_col_nxt;

  logic              r_row_en;
  logic              r_col_en;
  logic              r_sample_req;
  logic              r_busy;
  logic              r_frame_done;
  logic              r_cfg_err;

  logic              w_latch;
  logic              w_cfg_err_nxt;
  logic              w_win_ok;
  logic              w_ack;
  logic              w_tmr_load;
  logic [TMR_W-1:0]  w_tmr_val;
  logic              w_tmr_expired;

  assign w_win_ok = window_ok(16'(row_first), 16'(row_last), 16'(col_first), 16'(col_last));

`ifdef ROIC_SEQ_TESTPAT_EN
  // Test-pattern mode acknowledges on the first SAMPLE cycle.
  assign w_ack = tp_mode ? 1'b1 : sample_ack;
`else
  assign w_ack = sample_ack;
`endif

  roic_delay_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (w_tmr_load),
    .load_val (w_tmr_val),
    .expired  (w_tmr_expired)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_row_nxt     = r_row_addr;
    w_col_nxt     = r_col_addr;
    w_tmr_load    = 1'b0;
    w_tmr_val     = '0;
    w_cfg_err_nxt = 1'b0;
    w_latch       = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (frame_start) begin
          w_latch = 1'b1;
          if (w_win_ok) begin
            w_state_nxt = ST_INTEGRATE;
            w_row_nxt   = row_first;
            w_col_nxt   = col_first;
            w_tmr_load  = 1'b1;
            // Timer load is one less than the state length; zero integrates 1 cycle.
            w_tmr_val   = (integ_cycles == 16'd0) ? 16'd0 : integ_cycles - 16'd1;
          end else begin
            w_cfg_err_nxt = 1'b1;
          end
        end
      end
      ST_INTEGRATE: begin
        if (w_tmr_expired) w_state_nxt = ST_ROW_SETUP;
      end
      ST_ROW_SETUP: begin
        w_state_nxt = ST_COL_HOLD;
        w_tmr_load  = 1'b1;
        w_tmr_val   = {8'd0, r_hold};
      end
      ST_COL_HOLD: begin
        if (w_tmr_expired) w_state_nxt = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        if (w_ack) begin
          if (r_col_addr < r_col_last) begin
            w_col_nxt  = r_col_addr + 1'b1;
            w_tmr_load = 1'b1;
            if (r_gap == 8'd0) begin
              w_state_nxt = ST_COL_HOLD;
              w_tmr_val   = {8'd0, r_hold};
            end else begin
              w_state_nxt = ST_COL_GAP;
              w_tmr_val   = {8'd0, r_gap - 8'd1};
            end
          end else if (r_row_addr < r_row_last) begin
            w_row_nxt   = r_row_addr + 1'b1;
            w_col_nxt   = r_col_first;
            w_state_nxt = ST_ROW_SETUP;
          end else begin
            w_state_nxt = ST_DONE;
          end
        end
      end
      ST_COL_GAP: begin
        if (w_tmr_expired) begin
          w_state_nxt = ST_COL_HOLD;
          w_tmr_load  = 1'b1;
          w_tmr_val   = {8'd0, r_hold};
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // Abort overrides everything, including an ack arriving the same cycle.
    if (abort && (r_state != ST_IDLE)) begin
      w_state_nxt = ST_IDLE;
    end

    if (w_state_nxt == ST_IDLE) begin
      w_row_nxt = '0;
      w_col_nxt = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_hold       <= '0;
      r_gap        <= '0;
      r_row_last   <= '0;
      r_col_first  <= '0;
      r_col_last   <= '0;
      r_row_addr   <= '0;
      r_col_addr   <= '0;
      r_row_en     <= 1'b0;
      r_col_en     <= 1'b0;
      r_sample_req <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_cfg_err    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_row_addr <= w_row_nxt;
      r_col_addr <= w_col_nxt;
      if (w_latch) begin
        r_hold      <= hold_cycles;
        r_gap       <= gap_cycles;
        r_row_last  <= row_last;
        r_col_first <= col_first;
        r_col_last  <= col_last;
      end
      // Outputs are decoded from the state being entered so they align with it.
      r_busy       <= (w_state_nxt != ST_IDLE) && (w_state_nxt != ST_DONE);
      r_row_en     <= (w_state_nxt == ST_ROW_SETUP) || (w_state_nxt == ST_COL_HOLD) ||
                      (w_state_nxt == ST_SAMPLE)    || (w_state_nxt == ST_COL_GAP);
      r_col_en     <= (w_state_nxt == ST_COL_HOLD) || (w_state_nxt == ST_SAMPLE);
      r_sample_req <= (w_state_nxt == ST_SAMPLE);
      r_frame_done <= (w_state_nxt == ST_DONE);
      r_cfg_err    <= w_cfg_err_nxt;
    end
  end

  assign row_addr   = r_row_addr;
  assign col_addr   = r_col_addr;
  assign row_en     = r_row_en;
  assign col_en     = r_col_en;
  assign sample_req = r_sample_req;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;
  assign cfg_err    = r_cfg_err;

endmodule
